udp_sd_sector_writer: RTL and testbench

Receive direction of the SD/UDP image path: accepts UDP payload bytes from the application-layer receive interface and writes them to consecutive SD card sectors through the sd_card_top write port. Uses a two-sector ping-pong buffer, so reception of sector k+1 overlaps the SD write of sector k. Sits beside the BMP sender and shares the same sd_card_top instance, which is arbitrated at top level.

---
 rtl/sd_udp_pkg.sv | 20 ++
 rtl/sector_pingpong_buf.sv | 64 ++++++
 rtl/udp_sd_sector_writer.sv | 181 ++++++++++++++++++
 tb/tb_udp_sd_sector_writer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_udp_pkg.sv
// sd_udp_pkg: encodings shared by the SD/UDP receive writer and the BMP sender.
// Holds the state_code values, the default sector size and the writer FSM states.
package sd_udp_pkg;

   localparam int SD_SECTOR_BYTES = 512;

   localparam logic [3:0] SC_INIT     = 4'd0;
   localparam logic [3:0] SC_WAIT_ARM = 4'd1;
   localparam logic [3:0] SC_RECV     = 4'd2;
   localparam logic [3:0] SC_WRITING  = 4'd3;
   localparam logic [3:0] SC_DONE     = 4'd4;

   typedef enum logic [1:0] {
      WR_INIT,
      WR_WAIT_ARM,
      WR_RECV,
      WR_DONE
   } wr_state_t;

endpackage

// File: rtl/sector_pingpong_buf.sv
// sector_pingpong_buf: two-sector byte RAM with a registered read port.
// Each half carries a full flag and the number of real bytes it holds;
// reads beyond that length return zero, which implements flush padding
// without physically writing the pad bytes.
module sector_pingpong_buf
#(
   parameter int SECTOR_BYTES = 512,
   parameter int IDX_W        = $clog2(SECTOR_BYTES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic             wr_half,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic             mark_full,
   input  logic             mark_half,
   input  logic [IDX_W:0]   mark_len,
   input  logic             free,
   input  logic             free_half,
   input  logic             rd_en,
   input  logic             rd_half,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_data,
   output logic [1:0]       full
);

   logic [7:0]            mem [0:2*SECTOR_BYTES-1];
   logic [1:0][IDX_W:0]   len;

   // Byte write port
   // NOTE: the storage array has no reset; a RAM cannot be cleared in one
   // cycle, and the full flags / lengths already say which bytes are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_half, wr_idx}] <= wr_data;
   end

   // Registered read port, zero for indices past the recorded length
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= ({1'b0, rd_idx} < len[rd_half]) ? mem[{rd_half, rd_idx}] : 8'h00;
      end
   end

   // Per-half full flags and valid lengths
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= '0;
         len  <= '0;
      end else if (clear) begin
         full <= '0;
      end else begin
         if (mark_full) begin
            full[mark_half] <= 1'b1;
            len[mark_half]  <= mark_len;
         end
         if (free) full[free_half] <= 1'b0;
      end
   end

endmodule

// File: rtl/udp_sd_sector_writer.sv
// udp_sd_sector_writer: streams UDP payload bytes into consecutive SD sectors
// through a ping-pong buffer so reception of one sector overlaps the card
// write of the previous one.
// Optional build macro SD_WR_CHECKSUM_EN adds wr_checksum, the mod-2^16 sum
// of every byte delivered on sd_sec_write_data.
module udp_sd_sector_writer
   import sd_udp_pkg::*;
#(
   parameter int SECTOR_BYTES = SD_SECTOR_BYTES,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sd_init_done,
   input  logic              arm,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       num_sectors,
   input  logic              flush,
   input  logic              app_rx_data_valid,
   input  logic [7:0]        app_rx_data,
   output logic              sd_sec_write,
   output logic [ADDR_W-1:0] sd_sec_write_addr,
   output logic [7:0]        sd_sec_write_data,
   input  logic              sd_sec_write_data_req,
   input  logic              sd_sec_write_end,
   output logic [3:0]        state_code,
   output logic [15:0]       sectors_written,
   output logic              overflow,
   output logic              busy
`ifdef SD_WR_CHECKSUM_EN
   ,
   output logic [15:0]       wr_checksum
`endif
);

   localparam int IDX_W = $clog2(SECTOR_BYTES);
   localparam int CNT_W = IDX_W + 1;

   wr_state_t         state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [15:0]       num_sec_q, sectors_queued_q;
   logic [IDX_W-1:0]  byte_cnt_q, rd_idx_q;
   logic              fill_sel_q, drain_sel_q;
   logic [1:0]        full;

   logic              arm_take, accepting, byte_ok, byte_drop, last_byte;
   logic              flush_take, mark_full, start_wr, write_done, rd_en;
   logic [CNT_W-1:0]  cnt_after;

   // Arm is honoured only between sessions; fill stops once every sector is queued
   assign arm_take   = arm && (state_q == WR_WAIT_ARM || state_q == WR_DONE);
   assign accepting  = (state_q == WR_RECV) && (sectors_queued_q < num_sec_q);
   assign byte_ok    = accepting && app_rx_data_valid && !full[fill_sel_q];
   assign byte_drop  = accepting && app_rx_data_valid &&  full[fill_sel_q];
   assign last_byte  = byte_ok && (byte_cnt_q == IDX_W'(SECTOR_BYTES - 1));
   // A byte arriving with flush is stored first, so the flush sees the count after it
   assign cnt_after  = {1'b0, byte_cnt_q} + CNT_W'(byte_ok);
   assign flush_take = accepting && flush && !last_byte && (cnt_after != '0);
   assign mark_full  = last_byte || flush_take;
   assign start_wr   = (state_q == WR_RECV) && !sd_sec_write && full[drain_sel_q];
   assign write_done = sd_sec_write && sd_sec_write_end;
   assign rd_en      = sd_sec_write && sd_sec_write_data_req;

   sector_pingpong_buf #(.SECTOR_BYTES(SECTOR_BYTES), .IDX_W(IDX_W)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clear     (arm_take),
      .wr_en     (byte_ok),
      .wr_half   (fill_sel_q),
      .wr_idx    (byte_cnt_q),
      .wr_data   (app_rx_data),
      .mark_full (mark_full),
      .mark_half (fill_sel_q),
      .mark_len  (cnt_after),
      .free      (write_done),
      .free_half (drain_sel_q),
      .rd_en     (rd_en),
      .rd_half   (drain_sel_q),
      .rd_idx    (rd_idx_q),
      .rd_data   (sd_sec_write_data),
      .full      (full)
   );

   // Session, fill and drain bookkeeping
   // NOTE: every clocked process uses non-blocking assignments so that all
   // registers update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q            <= '0;
         num_sec_q         <= '0;
         sectors_queued_q  <= '0;
         sectors_written   <= '0;
         byte_cnt_q        <= '0;
         rd_idx_q          <= '0;
         fill_sel_q        <= 1'b0;
         drain_sel_q       <= 1'b0;
         overflow          <= 1'b0;
         sd_sec_write      <= 1'b0;
         sd_sec_write_addr <= '0;
      end else if (arm_take) begin
         base_q           <= base_addr;
         num_sec_q        <= num_sectors;
         sectors_queued_q <= '0;
         sectors_written  <= '0;
         byte_cnt_q       <= '0;
         rd_idx_q         <= '0;
         fill_sel_q       <= 1'b0;
         drain_sel_q      <= 1'b0;
         overflow         <= 1'b0;
      end else begin
         if (byte_drop) overflow <= 1'b1;
         if (byte_ok)   byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
         if (flush_take) byte_cnt_q <= '0;
         if (mark_full) begin
            fill_sel_q       <= ~fill_sel_q;
            sectors_queued_q <= sectors_queued_q + 1'b1;
         end
         if (start_wr) begin
            sd_sec_write      <= 1'b1;
            sd_sec_write_addr <= base_q + ADDR_W'(sectors_written);
         end
         if (rd_en) rd_idx_q <= rd_idx_q + 1'b1;
         if (write_done) begin
            sd_sec_write    <= 1'b0;
            drain_sel_q     <= ~drain_sel_q;
            sectors_written <= sectors_written + 1'b1;
            rd_idx_q        <= '0;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= WR_INIT;
      else     state_q <= state_d;
   end

   // Next state and status outputs
   // NOTE: defaults are assigned first so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      state_code = SC_INIT;
      busy       = 1'b0;
      case (state_q)
         WR_INIT: begin
            if (sd_init_done) state_d = WR_WAIT_ARM;
         end
         WR_WAIT_ARM: begin
            state_code = SC_WAIT_ARM;
            if (arm) state_d = WR_RECV;
         end
         WR_RECV: begin
            busy       = 1'b1;
            state_code = sd_sec_write ? SC_WRITING : SC_RECV;
            if (sectors_written == num_sec_q) state_d = WR_DONE;
         end
         WR_DONE: begin
            state_code = SC_DONE;
            if (arm) state_d = WR_RECV;
         end
         default: state_d = WR_INIT;
      endcase
   end

`ifdef SD_WR_CHECKSUM_EN
   logic rd_en_d;

   // Sum each byte the cycle it appears on sd_sec_write_data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_d     <= 1'b0;
         wr_checksum <= '0;
      end else begin
         rd_en_d <= rd_en;
         if (arm_take)     wr_checksum <= '0;
         else if (rd_en_d) wr_checksum <= wr_checksum + 16'(sd_sec_write_data);
      end
   end
`endif

endmodule

// File: tb/tb_udp_sd_sector_writer.sv
// tb_udp_sd_sector_writer: table-driven sessions plus hand-written corner
// sequences. A behavioural SD controller pops expected addresses and bytes
// from scoreboard queues filled as payload is driven.
module tb_udp_sd_sector_writer;
   import sd_udp_pkg::*;

   localparam int SB = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sd_init_done = 1'b0;
   logic        arm = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] num_sectors = '0;
   logic        flush = 1'b0;
   logic        app_rx_data_valid = 1'b0;
   logic [7:0]  app_rx_data = '0;
   logic        sd_sec_write;
   logic [31:0] sd_sec_write_addr;
   logic [7:0]  sd_sec_write_data;
   logic        sd_sec_write_data_req = 1'b0;
   logic        sd_sec_write_end = 1'b0;
   logic [3:0]  state_code;
   logic [15:0] sectors_written;
   logic        overflow;
   logic        busy;
`ifdef SD_WR_CHECKSUM_EN
   logic [15:0] wr_checksum;
`endif

   udp_sd_sector_writer dut (
      .clk                   (clk),
      .rst                   (rst),
      .sd_init_done          (sd_init_done),
      .arm                   (arm),
      .base_addr             (base_addr),
      .num_sectors           (num_sectors),
      .flush                 (flush),
      .app_rx_data_valid     (app_rx_data_valid),
      .app_rx_data           (app_rx_data),
      .sd_sec_write          (sd_sec_write),
      .sd_sec_write_addr     (sd_sec_write_addr),
      .sd_sec_write_data     (sd_sec_write_data),
      .sd_sec_write_data_req (sd_sec_write_data_req),
      .sd_sec_write_end      (sd_sec_write_end),
      .state_code            (state_code),
      .sectors_written       (sectors_written),
      .overflow              (overflow),
      .busy                  (busy)
`ifdef SD_WR_CHECKSUM_EN
      ,
      .wr_checksum           (wr_checksum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_bytes[$];
   logic [31:0] exp_addrs[$];
   int          pushed = 0;
   bit          hold_end = 1'b0;
   int          req_num = 0;
   int          svc_sectors = 0;
   int          write_cycles = 0;
   logic [15:0] cks_model = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   always @(posedge clk) if (sd_sec_write) write_cycles++;

   // Behavioural SD controller: one sector per sd_sec_write request
   task automatic service_sector();
      int          bad;
      logic [7:0]  e;
      logic [31:0] ea;
      bad = 0;
      req_num = 0;
      svc_sectors++;
      ea = (exp_addrs.size() > 0) ? exp_addrs.pop_front() : 32'hDEAD_BEEF;
      check("sector addr", sd_sec_write_addr, ea);
      check("state_code writing", state_code, SC_WRITING);
      for (int i = 0; i < SB; i++) begin
         sd_sec_write_data_req = 1'b1;
         req_num++;
         @(posedge clk); #1;
         sd_sec_write_data_req = 1'b0;
         if (rst) return;
         if (exp_bytes.size() > 0) begin
            e = exp_bytes.pop_front();
            cks_model += 16'(e);
            if (sd_sec_write_data !== e) bad++;
         end else begin
            bad++;
         end
         if (i % 8 == 7) begin @(posedge clk); #1; end
      end
      for (int c = 0; hold_end && !rst && c < 20000; c++) begin @(posedge clk); #1; end
      if (rst) return;
      check("sector data bad bytes", bad, 0);
      sd_sec_write_end = 1'b1;
      @(posedge clk); #1;
      sd_sec_write_end = 1'b0;
      check("write drops on end", sd_sec_write, 1'b0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (sd_sec_write && !rst) service_sector();
      end
   end

   task automatic do_arm(input logic [31:0] base, input logic [15:0] n);
      base_addr = base;
      num_sectors = n;
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      for (int i = 0; i < int'(n); i++) exp_addrs.push_back(base + 32'(i));
      pushed = 0;
      cks_model = '0;
   endtask

   task automatic stream(input int n, input int start, input bit cst, input logic [7:0] cval,
                         input int gap, input bit flush_last, input bit expect_it);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = cst ? cval : 8'(start + i);
         app_rx_data = b;
         app_rx_data_valid = 1'b1;
         if (flush_last && i == n - 1) flush = 1'b1;
         if (expect_it) begin exp_bytes.push_back(b); pushed++; end
         @(posedge clk); #1;
         app_rx_data_valid = 1'b0;
         flush = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic pad_expected();
      while (pushed % SB != 0) begin exp_bytes.push_back(8'h00); pushed++; end
   endtask

   task automatic wait_done();
      int c;
      c = 0;
      while (state_code !== SC_DONE && c < 20000) begin @(posedge clk); #1; c++; end
      check("state_code done", state_code, SC_DONE);
      check("busy after done", busy, 1'b0);
   endtask

   task automatic wait_written(input logic [15:0] n);
      int c;
      c = 0;
      while (sectors_written !== n && c < 20000) begin @(posedge clk); #1; c++; end
      check("sectors_written reached", sectors_written, n);
   endtask

   typedef struct {
      logic [31:0] base;
      logic [15:0] nsec;
      int          nbytes;
      bit          cst;
      logic [7:0]  cval;
      int          gap;
      bit          flush_last;
      logic [15:0] exp_written;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int c;
      int wc0;

      vecs[0] = '{32'h0000_2000, 16'd2, 1024, 1'b0, 8'h00, 0, 1'b0, 16'd2};
      vecs[1] = '{32'hFFFF_FFFF, 16'd3, 1536, 1'b0, 8'h00, 2, 1'b0, 16'd3};
      vecs[2] = '{32'h0000_0010, 16'd1, 100,  1'b1, 8'hA5, 0, 1'b1, 16'd1};
      vecs[3] = '{32'h0000_3000, 16'd1, 512,  1'b1, 8'hFF, 0, 1'b0, 16'd1};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset sd_sec_write", sd_sec_write, 1'b0);
      check("reset state_code", state_code, SC_INIT);
      check("reset sectors_written", sectors_written, 16'd0);
      check("reset overflow", overflow, 1'b0);
      check("reset busy", busy, 1'b0);
      rst = 1'b0;

      // Arm before the card is initialised is ignored
      num_sectors = 16'd5;
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      @(posedge clk); #1;
      check("arm ignored in INIT", state_code, SC_INIT);
      sd_init_done = 1'b1;
      @(posedge clk); #1;
      check("wait arm state", state_code, SC_WAIT_ARM);

      // Zero-sector session finishes without any write
      wc0 = write_cycles;
      do_arm(32'h0000_1234, 16'd0);
      @(posedge clk); #1;
      check("zero sectors done", state_code, SC_DONE);
      check("zero sectors no write", write_cycles - wc0, 0);

      // Table-driven sessions
      for (int v = 0; v < 4; v++) begin
         do_arm(vecs[v].base, vecs[v].nsec);
         check("busy after arm", busy, 1'b1);
         stream(vecs[v].nbytes, 0, vecs[v].cst, vecs[v].cval, vecs[v].gap, vecs[v].flush_last, 1'b1);
         if (vecs[v].flush_last) pad_expected();
         wait_done();
         check("session sectors_written", sectors_written, vecs[v].exp_written);
         check("session overflow", overflow, 1'b0);
`ifdef SD_WR_CHECKSUM_EN
         check("wr_checksum", wr_checksum, cks_model);
`endif
      end

      // Overflow: both halves full while the card withholds write_end
      hold_end = 1'b1;
      do_arm(32'h0000_0100, 16'd4);
      stream(1024, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      check("no overflow at 1024", overflow, 1'b0);
      stream(1, 0, 1'b1, 8'hEE, 0, 1'b0, 1'b0);
      check("overflow after drop", overflow, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      check("write held", sd_sec_write, 1'b1);
      hold_end = 1'b0;
      wait_written(16'd2);
      check("overflow sticky", overflow, 1'b1);

      // Reset in the middle of the third sector, at data request 200
      c = svc_sectors + 1;
      stream(512, 8'h40, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      wc0 = 0;
      while (!(svc_sectors >= c && req_num >= 200) && wc0 < 5000) begin @(posedge clk); wc0++; end
      check("reached req 200", req_num >= 200, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("async drop sd_sec_write", sd_sec_write, 1'b0);
      check("reset mid sectors_written", sectors_written, 16'd0);
      check("reset mid state_code", state_code, SC_INIT);
      check("reset mid overflow", overflow, 1'b0);
      check("reset mid busy", busy, 1'b0);
      check("reset mid addr", sd_sec_write_addr, 32'd0);
      check("reset mid data", sd_sec_write_data, 8'd0);
      exp_bytes.delete();
      exp_addrs.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("post reset wait arm", state_code, SC_WAIT_ARM);

      // Fresh session after reset, partial last sector closed by a standalone flush
      do_arm(32'h0000_0500, 16'd2);
      stream(700, 3, 1'b0, 8'h00, 1, 1'b0, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      pad_expected();
      wait_done();
      check("post reset sectors_written", sectors_written, 16'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
